dmem_requester: RTL

//  Initiator side of the data-memory interface: accepts one load/store at a time from the

---
 rtl/dmem_requester_pkg.sv | 24 ++
 rtl/dmem_requester_if.sv | 37 +++
 rtl/dmem_requester.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_requester_pkg.sv
// Shared types for the data-memory requester: FSM states, thread id and latched request.
package dmem_requester_pkg;

  // Width of the retry and backoff counters; both parameters are bounded to 15.
  localparam int unsigned CntW = 4;

  typedef logic [2:0] trd_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StBackoff,
    StDone
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    trd_t        trd;
  } mem_req_t;

endpackage

// File: rtl/dmem_requester_if.sv
// Data-memory bus between the requester (master) and the memory responder (slave).
// Response signals are registered by the memory and valid the cycle after a strobe.
interface dmem_requester_if;
  import dmem_requester_pkg::*;

  logic [31:0] d_addr;
  logic [31:0] d_wr_data;
  logic        d_rd;
  logic        d_wr;
  trd_t        d_trd;
  logic [31:0] d_rd_data;
  logic        d_miss;
  logic        d_segfault;

  modport master (
    output d_addr,
    output d_wr_data,
    output d_rd,
    output d_wr,
    output d_trd,
    input  d_rd_data,
    input  d_miss,
    input  d_segfault
  );

  modport slave (
    input  d_addr,
    input  d_wr_data,
    input  d_rd,
    input  d_wr,
    input  d_trd,
    output d_rd_data,
    output d_miss,
    output d_segfault
  );

endinterface

// File: rtl/dmem_requester.sv
// Initiator side of the data-memory interface. Accepts one load/store at a time, issues it,
// retries on miss after a fixed backoff, and returns the result plus per-thread exception
// pulses (segfault or retry exhaustion). All outputs are registered.
module dmem_requester
  import dmem_requester_pkg::*;
#(
  parameter int unsigned RETRY_DELAY = 4,
  parameter int unsigned MAX_RETRY   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  // Pipeline request
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  trd_t             req_trd,
  // Pipeline response
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output trd_t             resp_trd,
  output logic             resp_err,
  // Memory bus
  dmem_requester_if.master dmem,
  // Exception pulses to the CSR block, qualified by resp_trd
  output logic             seg_exp,
  output logic             to_exp
);

  localparam logic [CntW-1:0] MaxRetry    = CntW'(MAX_RETRY);
  localparam logic [CntW-1:0] BackoffLast = CntW'(RETRY_DELAY - 1);

  state_e              state_q;
  mem_req_t            req_q;
  logic [CntW-1:0]     retry_q;
  logic [CntW-1:0]     backoff_q;
  logic                rd_q;
  logic                wr_q;

  // req_q is zeroed on return to idle, so the address/data/thread lines read 0 there.
  assign dmem.d_addr    = req_q.addr;
  assign dmem.d_wr_data = req_q.wdata;
  assign dmem.d_trd     = req_q.trd;
  assign dmem.d_rd      = rd_q;
  assign dmem.d_wr      = wr_q;

  // Request FSM: latch, strobe, sample response, back off or complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      req_q      <= '0;
      retry_q    <= '0;
      backoff_q  <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_trd   <= '0;
      resp_err   <= 1'b0;
      seg_exp    <= 1'b0;
      to_exp     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_q     <= '{wr: req_wr, addr: req_addr, wdata: req_wdata, trd: req_trd};
            rd_q      <= ~req_wr;
            wr_q      <= req_wr;
            req_ready <= 1'b0;
            state_q   <= StIssue;
          end
        end

        StIssue: begin
          // Strobe lasts exactly one cycle.
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= StWait;
        end

        StWait: begin
          if (dmem.d_segfault) begin
            // Segfault takes priority over a simultaneous miss; never retried.
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_trd   <= req_q.trd;
            resp_err   <= 1'b1;
            seg_exp    <= 1'b1;
            state_q    <= StDone;
          end else if (dmem.d_miss && (retry_q < MaxRetry)) begin
            retry_q   <= retry_q + 1'b1;
            backoff_q <= '0;
            state_q   <= StBackoff;
          end else if (dmem.d_miss) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_trd   <= req_q.trd;
            resp_err   <= 1'b1;
            to_exp     <= 1'b1;
            state_q    <= StDone;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= req_q.wr ? 32'h0 : dmem.d_rd_data;
            resp_trd   <= req_q.trd;
            resp_err   <= 1'b0;
            state_q    <= StDone;
          end
        end

        StBackoff: begin
          // RETRY_DELAY silent cycles, then re-issue the same strobe.
          if (backoff_q == BackoffLast) begin
            rd_q    <= ~req_q.wr;
            wr_q    <= req_q.wr;
            state_q <= StIssue;
          end else begin
            backoff_q <= backoff_q + 1'b1;
          end
        end

        StDone: begin
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_trd   <= '0;
          resp_err   <= 1'b0;
          seg_exp    <= 1'b0;
          to_exp     <= 1'b0;
          req_q      <= '0;
          retry_q    <= '0;
          backoff_q  <= '0;
          req_ready  <= 1'b1;
          state_q    <= StIdle;
        end

        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
